// File: rtl/adc_sched_pkg.sv
// Shared types and defaults for the ADC conversion scheduler.
// Also used by the SPI ADC engine for its data/channel widths.
package adc_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int ADC_N_BITS = 10;
  localparam int ADC_CHAN_W = 3;

endpackage

// File: rtl/adc_conv_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from last_grant+1 with wrap at REQ_N.
module rr_arbiter #(
  parameter int REQ_N = 4,
  parameter int IW    = $clog2(REQ_N)
) (
  input  logic [REQ_N-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [IW-1:0]    winner,
  output logic             any_req
);

  int          idx;
  logic [IW-1:0] sel;

  assign any_req = |req;

  // Walk farthest-first so the nearest requester wins last.
  always_comb begin
    winner = '0;
    idx    = 0;
    sel    = '0;
    for (int k = REQ_N; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= REQ_N) idx = idx - REQ_N;
      sel = IW'(idx);
      if (req[sel]) winner = sel;
    end
  end

endmodule

// File: rtl/adc_conv_scheduler.sv
// Shares one SPI ADC engine among REQ_N requesters.
// Round-robin grant, one conversion in flight, timeout abort.
module adc_conv_scheduler
  import adc_sched_pkg::*;
#(
  parameter int REQ_N   = 4,
  parameter int CHAN_W  = ADC_CHAN_W,
  parameter int N_BITS  = ADC_N_BITS,
  parameter int TIMEOUT = 63
) (
  input  logic                      SCLK,
  input  logic                      reset_n,
  input  logic [REQ_N-1:0]          req,
  input  logic [REQ_N*CHAN_W-1:0]   req_chan,
  output logic [REQ_N-1:0]          ack,
  output logic [N_BITS-1:0]         result,
  output logic                      timeout_err,
  output logic [$clog2(REQ_N)-1:0]  grant_id,
  output logic                      conv_start,
  output logic [CHAN_W-1:0]         conv_chan,
  input  logic                      conv_busy,
  input  logic                      conv_done,
  input  logic [N_BITS-1:0]         conv_data
);

  localparam int IW = $clog2(REQ_N);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] winner;
  logic          any_req;
  logic [TW-1:0] timer;
  logic          err;
  logic          tmo_hit;
  logic          take;

  rr_arbiter #(
    .REQ_N (REQ_N),
    .IW    (IW)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign tmo_hit = (timer == TW'(TIMEOUT));
  assign take    = any_req && !conv_busy;

  always_ff @(posedge SCLK or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (take) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (conv_done || tmo_hit) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ack         = '0;
    conv_start  = (state == S_ISSUE);
    timeout_err = 1'b0;
    if (state == S_RESP) begin
      ack[grant_id] = 1'b1;
      timeout_err   = err;
    end
  end

  // Done wins over a coincident timeout.
  always_ff @(posedge SCLK or negedge reset_n) begin
    if (!reset_n) begin
      grant_id   <= '0;
      conv_chan  <= '0;
      last_grant <= IW'(REQ_N - 1);
      timer      <= '0;
      result     <= '0;
      err        <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (take) begin
            grant_id  <= winner;
            conv_chan <= req_chan[winner*CHAN_W +: CHAN_W];
          end
        end
        S_ISSUE: timer <= '0;
        S_WAIT: begin
          if (conv_done) begin
            result <= conv_data;
            err    <= 1'b0;
          end else if (tmo_hit) begin
            result <= '0;
            err    <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_RESP:  last_grant <= grant_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Self-checking bench for adc_conv_scheduler.
// Directed scenarios followed by randomized transactions.
module tb_adc_conv_scheduler;

  localparam int REQ_N   = 4;
  localparam int CHAN_W  = 3;
  localparam int N_BITS  = 10;
  localparam int TIMEOUT = 63;

  logic                    SCLK = 1'b0;
  logic                    reset_n;
  logic [REQ_N-1:0]        req;
  logic [REQ_N*CHAN_W-1:0] req_chan;
  logic [REQ_N-1:0]        ack;
  logic [N_BITS-1:0]       result;
  logic                    timeout_err;
  logic [1:0]              grant_id;
  logic                    conv_start;
  logic [CHAN_W-1:0]       conv_chan;
  logic                    conv_busy;
  logic                    conv_done;
  logic [N_BITS-1:0]       conv_data;

  int            n_chk = 0;
  int            n_fail = 0;
  int            last_g;
  logic [N_BITS-1:0] last_res;

  always #5 SCLK = ~SCLK;

  adc_conv_scheduler #(
    .REQ_N   (REQ_N),
    .CHAN_W  (CHAN_W),
    .N_BITS  (N_BITS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .SCLK        (SCLK),
    .reset_n     (reset_n),
    .req         (req),
    .req_chan    (req_chan),
    .ack         (ack),
    .result      (result),
    .timeout_err (timeout_err),
    .grant_id    (grant_id),
    .conv_start  (conv_start),
    .conv_chan   (conv_chan),
    .conv_busy   (conv_busy),
    .conv_done   (conv_done),
    .conv_data   (conv_data)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  // Round-robin rule: first pending index after last, mod REQ_N.
  function automatic int rr(input logic [REQ_N-1:0] m,
                            input int last);
    int idx;
    for (int k = 1; k <= REQ_N; k++) begin
      idx = (last + k) % REQ_N;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    reset_n   = 1'b0;
    req       = '0;
    req_chan  = '0;
    conv_busy = 1'b0;
    conv_done = 1'b0;
    conv_data = '0;
    tick();
    tick();
    reset_n  = 1'b1;
    last_g   = REQ_N - 1;
    last_res = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_result"}, 32'(result), 0);
    chk({tag, "_terr"}, 32'(timeout_err), 0);
    chk({tag, "_start"}, 32'(conv_start), 0);
    chk({tag, "_chan"}, 32'(conv_chan), 0);
    chk({tag, "_gid"}, 32'(grant_id), 0);
  endtask

  // One conversion: lat = cycles from conv_start to conv_done.
  task automatic txn(input int lat, input bit hang,
                     input logic [N_BITS-1:0] data,
                     input bit drop, output int gid);
    int wid;
    int early;
    bit seen;
    logic [CHAN_W-1:0] ech;
    logic [N_BITS-1:0] eres;
    wid  = rr(req, last_g);
    ech  = req_chan[wid*CHAN_W +: CHAN_W];
    gid  = -1;
    seen = 1'b0;
    for (int w = 0; w < 40; w++) begin
      if (conv_start) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("start_seen", 32'(seen), 1);
    if (!seen) return;
    gid = int'(grant_id);
    chk("grant_id", 32'(grant_id), 32'(wid));
    chk("conv_chan", 32'(conv_chan), 32'(ech));
    if (drop) begin
      req[wid]  = 1'b0;
      req_chan  = REQ_N*CHAN_W'($urandom);
    end
    tick();
    chk("start_once", 32'(conv_start), 0);
    early = 0;
    if (hang) begin
      for (int i = 0; i < TIMEOUT + 1; i++) begin
        if (ack != 0) early++;
        tick();
      end
    end else begin
      for (int i = 1; i < lat; i++) begin
        if (ack != 0) early++;
        tick();
      end
      conv_done = 1'b1;
      conv_data = data;
      tick();
      conv_done = 1'b0;
      conv_data = N_BITS'($urandom);
    end
    eres = hang ? '0 : data;
    chk("no_early_ack", 32'(early), 0);
    chk("ack", 32'(ack), 32'd1 << wid);
    chk("result", 32'(result), 32'(eres));
    chk("timeout_err", 32'(timeout_err), 32'(hang));
    chk("chan_frozen", 32'(conv_chan), 32'(ech));
    last_g   = wid;
    last_res = eres;
  endtask

  initial begin
    int gid;
    int cnt;
    int order [6];
    bit seen;
    order = '{0, 1, 3, 0, 1, 3};

    apply_reset();
    chk_zero("reset");

    // Single request, 3-cycle engine.
    req      = 4'b0001;
    req_chan = 12'h005;
    txn(3, 1'b0, 10'h2A7, 1'b0, gid);
    chk("single_gid", 32'(gid), 0);
    req = '0;
    tick();

    // Spurious done in IDLE.
    conv_done = 1'b1;
    conv_data = 10'h155;
    tick();
    conv_done = 1'b0;
    tick();
    chk("spur_result", 32'(result), 32'(last_res));
    chk("spur_ack", 32'(ack), 0);
    chk("spur_start", 32'(conv_start), 0);

    // Timeout followed by a normal conversion.
    req      = 4'b0100;
    req_chan = 12'(3) << 6;
    txn(0, 1'b1, '0, 1'b0, gid);
    txn(2, 1'b0, 10'h1C3, 1'b0, gid);
    req = '0;
    tick();

    // Busy hold-off.
    conv_busy = 1'b1;
    req       = 4'b0100;
    cnt       = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (conv_start) cnt++;
    end
    chk("busy_hold", 32'(cnt), 0);
    conv_busy = 1'b0;
    tick();
    chk("start_after_busy", 32'(conv_start), 1);
    txn(1, 1'b0, 10'h0F0, 1'b0, gid);
    req = 4'b0001;

    // Done coincident with the last timer value.
    txn(TIMEOUT + 1, 1'b0, 10'h3FF, 1'b0, gid);
    req = '0;

    // Fairness from a fresh reset.
    apply_reset();
    req      = 4'b1011;
    req_chan = {3'd7, 3'd6, 3'd2, 3'd1};
    for (int i = 0; i < 6; i++) begin
      txn(1 + i, 1'b0, N_BITS'(i * 37 + 5), 1'b0, gid);
      chk("fair_order", 32'(gid), 32'(order[i]));
    end
    req = '0;
    tick();

    // Reset in the middle of WAIT.
    req  = 4'b0001;
    seen = 1'b0;
    for (int w = 0; w < 10; w++) begin
      if (conv_start) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("rst_start_seen", 32'(seen), 1);
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    req     = '0;
    #1;
    chk_zero("rst_wait");
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack != 0) cnt++;
    end
    reset_n = 1'b1;
    last_g  = REQ_N - 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack != 0) cnt++;
    end
    chk("rst_no_ack", 32'(cnt), 0);
    req      = 4'b0110;
    req_chan = 12'h2A8;
    txn(2, 1'b0, 10'h099, 1'b0, gid);
    chk("rst_first_gid", 32'(gid), 1);

    // Randomized transactions.
    for (int t = 0; t < 16; t++) begin
      req      = REQ_N'($urandom_range(1, 15));
      req_chan = REQ_N*CHAN_W'($urandom);
      txn($urandom_range(1, 8),
          ($urandom_range(0, 7) == 0),
          N_BITS'($urandom),
          1'($urandom_range(0, 1)), gid);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
